// File: rtl/if_prefetch_if.sv
// Fetch-side bus of the instruction prefetch queue: instruction-memory
// address/data, decode-side valid/ready head port and the redirect request.
// master = prefetch queue, slave = environment (IM + decode + branch unit).
interface if_prefetch_if;
    logic [15:0] pc;             // fetch address to instruction memory
    logic [31:0] instr;          // IM word for pc, same cycle
    logic        valid_o;        // queue head valid
    logic        ready_i;        // decode accepts the head
    logic [31:0] instr_o;        // head instruction word
    logic [15:0] pc_o;           // head fetch address
    logic        redirect_i;     // branch/jump redirect request
    logic [15:0] redirect_pc_i;  // redirect target

    modport master (
        output pc, valid_o, instr_o, pc_o,
        input  instr, ready_i, redirect_i, redirect_pc_i
    );

    modport slave (
        input  pc, valid_o, instr_o, pc_o,
        output instr, ready_i, redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction prefetch queue: fetches sequentially from IM into a DEPTH-entry queue.
// Latency: IM word fetched in cycle N is at the head in cycle N+1; 1 instr/cycle.
// Backpressure: ready_i low holds the head; fetching stops when full, redirect flushes.
// Ports: clk, rst (sync, active-high), bus (if_prefetch_if.master); with
// IF_PREFETCH_STATS_EN defined an extra stall_cnt[15:0] output counts
// cycles with valid_o && !ready_i (saturating).
module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    if_prefetch_if.master bus
`ifdef IF_PREFETCH_STATS_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int              AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);
    localparam logic [31:0]     NOP  = 32'h0000_0013;

    logic [31:0]   q_instr [DEPTH];
    logic [15:0]   q_pc    [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   fpc;

    logic          valid;
    logic          pop;
    logic          push;
    logic [15:0]   pc_now;

    // Low address bits of the redirect target are forced to word alignment.
    logic          unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^bus.redirect_pc_i[1:0];

    // Outputs are masked by rst so the reset cycle itself already shows the
    // post-reset view (empty queue, RESET_PC), and no pop can occur in it.
    always_comb begin
        valid  = (count != '0) && !rst;
        pop    = valid && bus.ready_i && !bus.redirect_i;
        push   = !rst && !bus.redirect_i && ((count != FULL) || pop);
        pc_now = rst ? RESET_PC : fpc;

        bus.pc      = pc_now;
        bus.valid_o = valid;
        bus.instr_o = valid ? q_instr[rd_ptr] : NOP;
        bus.pc_o    = valid ? q_pc[rd_ptr]    : pc_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc    <= RESET_PC;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.redirect_i) begin
            // Flush: the offered head is dropped, not retired.
            fpc    <= {bus.redirect_pc_i[15:2], 2'b00};
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                fpc    <= fpc + 16'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage needs no reset; entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= bus.instr;
            q_pc[wr_ptr]    <= fpc;
        end
    end

`ifdef IF_PREFETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (valid && !bus.ready_i && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Directed self-checking bench for if_prefetch (DEPTH=4, RESET_PC=0).
// The instruction memory is modelled as a pure function of pc, so every
// expected instr_o is derived from the expected pc_o.
module tb_if_prefetch;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_prefetch_if bus ();

`ifdef IF_PREFETCH_STATS_EN
    logic [15:0] stall_cnt;
`endif

    if_prefetch #(
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IF_PREFETCH_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    function automatic logic [31:0] im_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    assign bus.instr = im_word(bus.pc);

    localparam logic [31:0] NOP = 32'h0000_0013;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [15:0] exp_pc);
        check({tag, " valid"}, {31'd0, bus.valid_o}, 32'd1);
        check({tag, " pc_o"},  {16'd0, bus.pc_o}, {16'd0, exp_pc});
        check({tag, " instr"}, bus.instr_o, im_word(exp_pc));
    endtask

    task automatic check_empty(input string tag, input logic [15:0] exp_fpc);
        check({tag, " valid"}, {31'd0, bus.valid_o}, 32'd0);
        check({tag, " pc"},    {16'd0, bus.pc},   {16'd0, exp_fpc});
        check({tag, " pc_o"},  {16'd0, bus.pc_o}, {16'd0, exp_fpc});
        check({tag, " instr"}, bus.instr_o, NOP);
    endtask

    initial begin
        rst               = 1'b1;
        bus.ready_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 16'h0000;
        step();
        step();

        // Reset state
        check_empty("reset", 16'h0000);
`ifdef IF_PREFETCH_STATS_EN
        check("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif

        // Streaming from empty: one instruction per cycle, 0,4,...,28
        rst         = 1'b0;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check_head($sformatf("stream%0d", i), 16'(4 * i));
        end

        // Fill with decode stalled: head holds, fetch stops at 0x10
        rst         = 1'b1;
        bus.ready_i = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_head($sformatf("stall%0d", i), 16'h0000);
        end
        check("full pc hold", {16'd0, bus.pc}, 32'h0000_0010);
        step();
        check("full pc hold2", {16'd0, bus.pc}, 32'h0000_0010);
`ifdef IF_PREFETCH_STATS_EN
        check("stall_cnt", {16'd0, stall_cnt}, 32'd10);
`endif

        // Full queue: one pop+push keeps it full, fetch advances by one word
        bus.ready_i = 1'b1;
        step();
        check_head("full popush", 16'h0004);
        check("full popush pc", {16'd0, bus.pc}, 32'h0000_0014);

        // Redirect with ready high on a full queue: flush, no skip/duplicate
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 16'h0100;
        step();
        check_empty("redir full", 16'h0100);
        bus.redirect_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_head($sformatf("after redir%0d", i), 16'(16'h0100 + 4 * i));
        end

        // Build count=3 with head held stable, then redirect to unaligned 0x42
        bus.ready_i = 1'b0;
        step();
        check_head("hold a", 16'h010C);
        step();
        check_head("hold b", 16'h010C);
        check("cnt3 pc", {16'd0, bus.pc}, 32'h0000_0118);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 16'h0042;
        step();
        check_empty("redir 42", 16'h0040);

        // Redirect while already empty: no spurious entry
        bus.redirect_pc_i = 16'hFFF8;
        bus.ready_i       = 1'b1;
        step();
        check_empty("redir empty", 16'hFFF8);

        // Address wrap past 0xFFFC
        bus.redirect_i = 1'b0;
        step();
        check_head("wrap0", 16'hFFF8);
        step();
        check_head("wrap1", 16'hFFFC);
        step();
        check_head("wrap2", 16'h0000);
        step();
        check_head("wrap3", 16'h0004);

        // Fill, then reset mid-operation
        bus.ready_i = 1'b0;
        step();
        step();
        step();
        check_head("prefill", 16'h0004);
        check("prefill pc", {16'd0, bus.pc}, 32'h0000_0014);
        rst = 1'b1;
        #1;
        check_empty("rst cycle", 16'h0000);
        step();
        check_empty("rst after", 16'h0000);
`ifdef IF_PREFETCH_STATS_EN
        check("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
        rst         = 1'b0;
        bus.ready_i = 1'b1;
        step();
        check_head("post rst", 16'h0000);
        step();
        check_head("post rst2", 16'h0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning prefetch queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 16'h0000, meaning first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 pc  output  16  address driven to the instruction memory; IM returns instr combinationally in the same cycle.
REQ-006 instr  input  32  instruction word returned by the instruction memory for pc.
REQ-007 valid_o  output  1  queue head holds a valid instruction.
REQ-008 ready_i  input  1  consumer (decode) accepts the head this cycle.
REQ-009 instr_o  output  32  head instruction word.
REQ-010 pc_o  output  16  address the head instruction was fetched from.
REQ-011 redirect_i  input  1  branch/jump redirect request.
REQ-012 redirect_pc_i  input  16  redirect target address.

Function
REQ-013 The block SHALL hold a fetch address register fpc; pc SHALL equal fpc combinationally.
REQ-014 The block SHALL keep an occupancy count 0..DEPTH; valid_o SHALL equal (count != 0).
REQ-015 pop = valid_o && ready_i; push = !redirect_i && (count < DEPTH || pop).
REQ-016 On push, {instr, fpc} SHALL be written at the tail and fpc SHALL advance by 4, wrapping modulo 2^16 (16'hFFFC -> 16'h0000).
REQ-017 On pop, the head SHALL retire; instr_o/pc_o SHALL show the next entry in the following cycle.
REQ-018 Push and pop in the same cycle SHALL leave count unchanged, including when count == DEPTH.
REQ-019 When count == DEPTH and no pop, no push SHALL occur and fpc SHALL hold.
REQ-020 Redirect SHALL take priority over push and pop: count -> 0, fpc -> {redirect_pc_i[15:2], 2'b00}; the head offered that cycle SHALL NOT count as consumed.
REQ-021 Redirect while count == 0 SHALL behave identically (no spurious entry).
REQ-022 Latency: an address presented on pc in cycle N SHALL appear at the head no earlier than cycle N+1; from empty with ready_i high, throughput SHALL be one instruction per cycle.
REQ-023 instr_o/pc_o SHALL be stable while valid_o && !ready_i (no change without pop or redirect).
REQ-024 When valid_o is 0, instr_o SHALL read 32'h00000013 (NOP) and pc_o SHALL read fpc.

Reset
REQ-025 With rst high at a clock edge: fpc -> RESET_PC, count -> 0, queue pointers -> 0; rst SHALL override redirect_i, push and pop.
REQ-026 Outputs during/after reset: valid_o = 0, instr_o = 32'h00000013, pc_o = RESET_PC, pc = RESET_PC.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries; the first post-reset head SHALL be the instruction at RESET_PC.

Configuration
REQ-028 Macro IF_PREFETCH_STATS_EN, when defined, SHALL add output stall_cnt [15:0] counting cycles with valid_o && !ready_i, saturating at 16'hFFFF, cleared by rst.
REQ-029 Without IF_PREFETCH_STATS_EN the port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Reset then ready_i = 1 for 8 cycles with IM preloaded -> pc_o sequence 0,4,8,...,28 with matching instr_o, valid_o high from the first cycle after reset release.
REQ-031 ready_i = 0 for 10 cycles after reset -> count saturates at 4, pc holds at 16'h0010, head stays pc_o = 0; stall_cnt = 10 when IF_PREFETCH_STATS_EN is defined.
REQ-032 Redirect to 16'h0042 while count = 3 -> next cycle valid_o = 0, pc = 16'h0040; the cycle after, pc_o = 16'h0040.
REQ-033 Redirect with ready_i = 1 on a full queue -> no pop counted, count = 0, no duplicate or skipped PCs after the target.
REQ-034 Redirect to 16'hFFF8 with ready_i = 1 -> pc_o sequence FFF8, FFFC, 0000, 0004.
REQ-035 rst pulse while the queue is full -> valid_o = 0 for the reset cycle, then pc_o = RESET_PC with instr_o = IM word 0.
